// File: rtl/mem_arbiter_pkg.sv
// Shared typedefs for the two-port memory arbiter: FSM state encoding and port indices.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection for the two request ports.
// pointer holds the index of the last granted port; on contention the other port wins.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pointer,
    output logic [1:0] winner
);

    always_comb begin
        winner = 2'b00;
        if (req[PORT_CPU] && (!req[PORT_DBG] || pointer)) begin
            winner[PORT_CPU] = 1'b1;
        end else if (req[PORT_DBG]) begin
            winner[PORT_DBG] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter: IDLE/RESP sample requests, ACCESS drives the memory strobe.
// Define ARB_ROUND_ROBIN_EN for alternating priority on contention; otherwise port 0 always wins.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    arb_state_t        state_reg;
    logic              we_reg;
    logic [1:0]        gnt_reg;
    logic [1:0]        rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              mem_rd_reg;
    logic              mem_wr_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_din_reg;

    logic [1:0] winner;
    logic       pointer;
    logic       sel;

`ifdef ARB_ROUND_ROBIN_EN
    logic pointer_reg;
    assign pointer = pointer_reg;
`else
    assign pointer = 1'b1;
`endif

    arb_pick u_pick (
        .req     (req),
        .pointer (pointer),
        .winner  (winner)
    );

    assign sel = winner[PORT_DBG];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            gnt_reg      <= 2'b00;
            rvalid_reg   <= 2'b00;
            rdata_reg    <= '0;
            mem_rd_reg   <= 1'b0;
            mem_wr_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_din_reg  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            pointer_reg  <= 1'b1;
`endif
        end else begin
            gnt_reg    <= 2'b00;
            rvalid_reg <= 2'b00;
            mem_rd_reg <= 1'b0;
            mem_wr_reg <= 1'b0;
            case (state_reg)
                IDLE, RESP: begin
                    // Memory data is only valid during the read response cycle; keep it afterwards.
                    if (rvalid_reg != 2'b00) begin
                        rdata_reg <= mem_dout;
                    end
                    if (req != 2'b00) begin
                        state_reg    <= ACCESS;
                        gnt_reg      <= winner;
                        we_reg       <= we[sel];
                        mem_rd_reg   <= ~we[sel];
                        mem_wr_reg   <= we[sel];
                        mem_addr_reg <= sel ? addr1 : addr0;
                        mem_din_reg  <= sel ? wdata1 : wdata0;
`ifdef ARB_ROUND_ROBIN_EN
                        pointer_reg  <= sel;
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ACCESS: begin
                    state_reg <= RESP;
                    if (!we_reg) begin
                        rvalid_reg <= gnt_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_reg;
    assign rvalid   = rvalid_reg;
    assign rdata    = (rvalid_reg != 2'b00) ? mem_dout : rdata_reg;
    assign mem_rd   = mem_rd_reg;
    assign mem_wr   = mem_wr_reg;
    assign mem_addr = mem_addr_reg;
    assign mem_din  = mem_din_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous-read memory model.
module tb_mem_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_;
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [1:0]        gnt, rvalid;
    logic [DATA_W-1:0] rdata;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    logic [DATA_W-1:0] mem [32];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .req      (req),
        .we       (we),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    // Memory model: contents preset while reset is low (addr 5 = A7, others addr^5A).
    always @(posedge clk) begin
        if (!rst_) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= (i == 5) ? 8'hA7 : (8'(i) ^ 8'h5A);
            end
        end else begin
            if (mem_wr) mem[mem_addr] <= mem_din;
            if (mem_rd) mem_dout <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [1:0] cont_exp [4];
    logic [7:0] cont_data;

    initial begin
        rst_ = 1'b0;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
`ifdef ARB_ROUND_ROBIN_EN
        cont_exp[0] = 2'b01; cont_exp[1] = 2'b10; cont_exp[2] = 2'b01; cont_exp[3] = 2'b10;
`else
        cont_exp[0] = 2'b01; cont_exp[1] = 2'b01; cont_exp[2] = 2'b01; cont_exp[3] = 2'b01;
`endif
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_strobes", 32'({mem_rd, mem_wr}), 32'h0);
        check("rst_addr_din", 32'({mem_addr, mem_din}), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        tick(); tick();
        rst_ = 1'b1;
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);

        // Single read of address 5 by the CPU port.
        req = 2'b01; we = 2'b00; addr0 = 5'd5;
        tick();
        check("rd_gnt", 32'(gnt), 32'h1);
        check("rd_strobes", 32'({mem_rd, mem_wr}), 32'h2);
        check("rd_addr", 32'(mem_addr), 32'd5);
        req = 2'b00;
        tick();
        check("rd_rvalid", 32'(rvalid), 32'h1);
        check("rd_rdata", 32'(rdata), 32'hA7);
        check("rd_resp_gnt", 32'(gnt), 32'h0);
        check("rd_resp_strobes", 32'({mem_rd, mem_wr}), 32'h0);
        tick();
        check("rd_idle_rvalid", 32'(rvalid), 32'h0);
        check("rd_hold_rdata", 32'(rdata), 32'hA7);
        check("rd_hold_addr", 32'(mem_addr), 32'd5);

        // Debug port writes 3C to 31, then reads it straight back.
        req = 2'b10; we = 2'b10; addr1 = 5'd31; wdata1 = 8'h3C;
        tick();
        check("wr_gnt", 32'(gnt), 32'h2);
        check("wr_strobes", 32'({mem_rd, mem_wr}), 32'h1);
        check("wr_addr", 32'(mem_addr), 32'd31);
        check("wr_din", 32'(mem_din), 32'h3C);
        we = 2'b00;
        tick();
        check("wr_no_rvalid", 32'(rvalid), 32'h0);
        check("wr_hold_din", 32'(mem_din), 32'h3C);
        tick();
        check("rb_gnt", 32'(gnt), 32'h2);
        check("rb_strobes", 32'({mem_rd, mem_wr}), 32'h2);
        req = 2'b00;
        tick();
        check("rb_rvalid", 32'(rvalid), 32'h2);
        check("rb_rdata", 32'(rdata), 32'h3C);
        tick();

        // Contention: both ports reading, held for four accesses.
        req = 2'b11; we = 2'b00; addr0 = 5'd1; addr1 = 5'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("cont_gnt%0d", i), 32'(gnt), 32'(cont_exp[i]));
            check($sformatf("cont_strobes%0d", i), 32'({mem_rd, mem_wr}), 32'h2);
            if (i == 3) req = 2'b00;
            tick();
            cont_data = (cont_exp[i] == 2'b01) ? 8'h5B : 8'h58;
            check($sformatf("cont_gap%0d", i), 32'(gnt), 32'h0);
            check($sformatf("cont_rvalid%0d", i), 32'(rvalid), 32'(cont_exp[i]));
            check($sformatf("cont_rdata%0d", i), 32'(rdata), 32'(cont_data));
        end
        tick();
        check("cont_done_gnt", 32'(gnt), 32'h0);

        // Reset asserted during ACCESS of a read.
        req = 2'b01; we = 2'b00; addr0 = 5'd5;
        tick();
        check("rm_gnt", 32'(gnt), 32'h1);
        rst_ = 1'b0;
        #1;
        check("rm_gnt_clr", 32'(gnt), 32'h0);
        check("rm_strobes_clr", 32'({mem_rd, mem_wr}), 32'h0);
        check("rm_addr_clr", 32'(mem_addr), 32'h0);
        check("rm_rdata_clr", 32'(rdata), 32'h0);
        req = 2'b00;
        tick();
        rst_ = 1'b1;
        tick();
        check("rm_no_rvalid", 32'(rvalid), 32'h0);
        tick();
        check("rm_no_rvalid2", 32'(rvalid), 32'h0);
        req = 2'b01;
        tick();
        check("rm_new_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        tick();
        check("rm_new_rvalid", 32'(rvalid), 32'h1);
        check("rm_new_rdata", 32'(rdata), 32'hA7);
        tick();

        // Debug request pulsed only during ACCESS is never granted.
        req = 2'b01; addr0 = 5'd1;
        tick();
        check("ab_gnt", 32'(gnt), 32'h1);
        req = 2'b10;
        tick();
        req = 2'b00;
        check("ab_rvalid", 32'(rvalid), 32'h1);
        check("ab_rdata", 32'(rdata), 32'h5B);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("idle_gnt%0d", i), 32'(gnt), 32'h0);
            check($sformatf("idle_strobes%0d", i), 32'({mem_rd, mem_wr}), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
